// File: rtl/triage_prioq_if.sv
// Handshake bundle for the triage priority queue: enqueue side, dequeue side and status.
interface triage_prioq_if #(
    parameter int ID_W  = 2,
    parameter int PRI_W = 2,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enq_valid;
    logic [ID_W-1:0]  enq_id;
    logic [PRI_W-1:0] enq_pri;
    logic             enq_ready;
    logic             deq_req;
    logic             deq_valid;
    logic [ID_W-1:0]  deq_id;
    logic [PRI_W-1:0] deq_pri;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             enq_drop;
    logic             deq_err;

    modport master (
        output enq_valid, enq_id, enq_pri, deq_req,
        input  enq_ready, deq_valid, deq_id, deq_pri, count, full, empty, enq_drop, deq_err
    );

    modport slave (
        input  enq_valid, enq_id, enq_pri, deq_req,
        output enq_ready, deq_valid, deq_id, deq_pri, count, full, empty, enq_drop, deq_err
    );
endinterface

// File: rtl/triage_prioq.sv
// Aging priority queue: arrival-ordered compacted slots, highest-priority (oldest on tie) dequeue,
// with a one-step priority boost every AGE_CYC cycles of residence.
module triage_prioq #(
    parameter int ID_W    = 2,
    parameter int PRI_W   = 2,
    parameter int DEPTH   = 4,
    parameter int AGE_CYC = 8
) (
    input logic           clk,
    input logic           rst_n,
    triage_prioq_if.slave q
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int AGE_W = (AGE_CYC > 1) ? $clog2(AGE_CYC) : 1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [PRI_W-1:0] pri;
        logic [AGE_W-1:0] age;
    } slot_t;

    slot_t            slots_q [DEPTH];
    slot_t            slots_nxt [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tail;
    logic [SEL_W-1:0] sel;
    logic [PRI_W-1:0] best;
    logic             full;
    logic             empty;
    logic             do_enq;
    logic             do_deq;
    logic             deq_valid_q;
    logic [ID_W-1:0]  deq_id_q;
    logic [PRI_W-1:0] deq_pri_q;
    logic             enq_drop_q;
    logic             deq_err_q;

    // Saturating aging step: priority stops at all-ones and its age is pinned to 0 there.
    function automatic slot_t age_step(input slot_t s);
        slot_t r;
        r = s;
        if (AGE_CYC != 0) begin
            if (s.pri == '1) begin
                r.age = '0;
            end else if (s.age == AGE_W'(AGE_CYC - 1)) begin
                r.pri = s.pri + 1'b1;
                r.age = '0;
            end else begin
                r.age = s.age + 1'b1;
            end
        end
        return r;
    endfunction

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign do_enq = q.enq_valid && !full;
    assign do_deq = q.deq_req && !empty;

    // Strict greater-than keeps the lowest (oldest) slot on a priority tie.
    always_comb begin
        sel  = '0;
        best = slots_q[0].pri;
        for (int i = 1; i < DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q && slots_q[i].pri > best) begin
                sel  = SEL_W'(i);
                best = slots_q[i].pri;
            end
        end
    end

    always_comb begin
        tail = cnt_q - CNT_W'(do_deq);
        for (int i = 0; i < DEPTH; i++) begin
            slots_nxt[i] = age_step(slots_q[i]);
            if (do_deq && SEL_W'(i) >= sel)
                slots_nxt[i] = age_step(slots_q[(i < DEPTH - 1) ? i + 1 : i]);
            if (do_enq && CNT_W'(i) == tail) begin
                slots_nxt[i].id  = q.enq_id;
                slots_nxt[i].pri = q.enq_pri;
                slots_nxt[i].age = '0;
            end
        end
    end

    // Slot payload: occupancy is defined by cnt_q alone, so the data needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            slots_q[i] <= slots_nxt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            deq_valid_q <= 1'b0;
            deq_id_q    <= '0;
            deq_pri_q   <= '0;
            enq_drop_q  <= 1'b0;
            deq_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + CNT_W'(do_enq) - CNT_W'(do_deq);
            deq_valid_q <= do_deq;
            enq_drop_q  <= q.enq_valid && full;
            deq_err_q   <= q.deq_req && empty;
            if (do_deq) begin
                deq_id_q  <= slots_q[sel].id;
                deq_pri_q <= slots_q[sel].pri;
            end
        end
    end

    assign q.enq_ready = !full;
    assign q.full      = full;
    assign q.empty     = empty;
    assign q.count     = cnt_q;
    assign q.deq_valid = deq_valid_q;
    assign q.deq_id    = deq_id_q;
    assign q.deq_pri   = deq_pri_q;
    assign q.enq_drop  = enq_drop_q;
    assign q.deq_err   = deq_err_q;
endmodule

// File: tb/tb_triage_prioq.sv
// Directed bench for triage_prioq at default parameters with hand-computed expectations.
module tb_triage_prioq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    triage_prioq_if #(.ID_W(2), .PRI_W(2), .DEPTH(4)) bus ();

    triage_prioq #(.ID_W(2), .PRI_W(2), .DEPTH(4), .AGE_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic enq(input logic [1:0] id, input logic [1:0] pri);
        bus.enq_valid = 1'b1;
        bus.enq_id    = id;
        bus.enq_pri   = pri;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    task automatic deq();
        bus.deq_req = 1'b1;
        tick();
        bus.deq_req = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_id    = '0;
        bus.enq_pri   = '0;
        bus.deq_req   = 1'b0;

        // Reset state, before and across clock edges
        #3;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_enq_ready", 32'(bus.enq_ready), 1);
        chk("rst_deq_valid", 32'(bus.deq_valid), 0);
        chk("rst_deq_id", 32'(bus.deq_id), 0);
        chk("rst_deq_pri", 32'(bus.deq_pri), 0);
        chk("rst_drop", 32'(bus.enq_drop), 0);
        chk("rst_err", 32'(bus.deq_err), 0);
        bus.enq_valid = 1'b1;
        idle(2);
        bus.enq_valid = 1'b0;
        chk("rst_hold_count", 32'(bus.count), 0);
        rst_n = 1'b1;

        // Priority selection
        enq(2'b11, 2'b00);
        chk("pri_count1", 32'(bus.count), 1);
        enq(2'b10, 2'b10);
        chk("pri_count2", 32'(bus.count), 2);
        deq();
        chk("pri_valid", 32'(bus.deq_valid), 1);
        chk("pri_id", 32'(bus.deq_id), 2);
        chk("pri_pri", 32'(bus.deq_pri), 2);
        chk("pri_count", 32'(bus.count), 1);
        tick();
        chk("pri_valid_drop", 32'(bus.deq_valid), 0);
        chk("pri_id_hold", 32'(bus.deq_id), 2);
        deq();
        chk("pri_last_id", 32'(bus.deq_id), 3);
        chk("pri_last_pri", 32'(bus.deq_pri), 0);
        chk("pri_empty", 32'(bus.empty), 1);

        // Tie order
        enq(2'b01, 2'b10);
        enq(2'b10, 2'b10);
        deq();
        chk("tie_first", 32'(bus.deq_id), 1);
        deq();
        chk("tie_second", 32'(bus.deq_id), 2);
        chk("tie_valid", 32'(bus.deq_valid), 1);
        chk("tie_count", 32'(bus.count), 0);

        // Bounds: fill, overflow, overflow with dequeue, drain, underflow
        enq(2'b00, 2'b01);
        enq(2'b01, 2'b01);
        enq(2'b10, 2'b01);
        chk("bnd_not_full", 32'(bus.full), 0);
        enq(2'b11, 2'b01);
        chk("bnd_full", 32'(bus.full), 1);
        chk("bnd_ready", 32'(bus.enq_ready), 0);
        chk("bnd_count4", 32'(bus.count), 4);
        enq(2'b00, 2'b11);
        chk("bnd_drop", 32'(bus.enq_drop), 1);
        chk("bnd_drop_count", 32'(bus.count), 4);
        bus.deq_req = 1'b1;
        enq(2'b00, 2'b11);
        bus.deq_req = 1'b0;
        chk("bnd_drop_deq", 32'(bus.enq_drop), 1);
        chk("bnd_drop_deq_count", 32'(bus.count), 3);
        chk("bnd_drop_deq_id", 32'(bus.deq_id), 0);
        deq();
        chk("bnd_drop_clear", 32'(bus.enq_drop), 0);
        chk("bnd_drain1", 32'(bus.deq_id), 1);
        deq();
        chk("bnd_drain2", 32'(bus.deq_id), 2);
        deq();
        chk("bnd_drain3", 32'(bus.deq_id), 3);
        chk("bnd_drain3_pri", 32'(bus.deq_pri), 1);
        chk("bnd_empty", 32'(bus.empty), 1);
        deq();
        chk("bnd_err", 32'(bus.deq_err), 1);
        chk("bnd_err_valid", 32'(bus.deq_valid), 0);
        chk("bnd_err_id_hold", 32'(bus.deq_id), 3);
        chk("bnd_err_count", 32'(bus.count), 0);
        tick();
        chk("bnd_err_clear", 32'(bus.deq_err), 0);

        // Aging boost and saturation
        enq(2'b00, 2'b00);
        idle(8);
        enq(2'b01, 2'b00);
        deq();
        chk("age_id", 32'(bus.deq_id), 0);
        chk("age_pri", 32'(bus.deq_pri), 1);
        deq();
        chk("age_young_id", 32'(bus.deq_id), 1);
        chk("age_young_pri", 32'(bus.deq_pri), 0);
        enq(2'b10, 2'b11);
        idle(40);
        deq();
        chk("sat_id", 32'(bus.deq_id), 2);
        chk("sat_pri", 32'(bus.deq_pri), 3);
        chk("sat_count", 32'(bus.count), 0);

        // Simultaneous enqueue and dequeue
        enq(2'b11, 2'b01);
        bus.deq_req = 1'b1;
        enq(2'b10, 2'b11);
        bus.deq_req = 1'b0;
        chk("sim_id", 32'(bus.deq_id), 3);
        chk("sim_pri", 32'(bus.deq_pri), 1);
        chk("sim_count", 32'(bus.count), 1);
        deq();
        chk("sim_next_id", 32'(bus.deq_id), 2);
        chk("sim_next_pri", 32'(bus.deq_pri), 3);

        // Reset mid-operation, then first enqueue straight after release
        enq(2'b01, 2'b00);
        enq(2'b10, 2'b01);
        enq(2'b11, 2'b10);
        chk("mid_count3", 32'(bus.count), 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_deq_id", 32'(bus.deq_id), 0);
        chk("mid_rst_deq_pri", 32'(bus.deq_pri), 0);
        @(negedge clk);
        rst_n = 1'b1;
        enq(2'b01, 2'b01);
        chk("post_rst_count", 32'(bus.count), 1);
        deq();
        chk("post_rst_id", 32'(bus.deq_id), 1);
        chk("post_rst_empty", 32'(bus.empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
